// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the execute-stage branch logic.
package riscv_pkg;

  // Conditional branch kinds, encoded as their funct3 field.
  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_instr;

  // Major opcode of the B-type (conditional branch) group.
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // True when the opcode field selects the conditional branch group.
  function automatic logic is_branch_opc(input logic [6:0] opc);
    return (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: decodes funct3 and compares the two operands.
// cond is only meaningful when funct3_ok is high.
module branch_cmp
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            cond,
  output logic            funct3_ok
);

  // Select the comparison implied by funct3; reserved encodings are flagged.
  always_comb begin
    cond      = 1'b0;
    funct3_ok = 1'b1;
    case (funct3)
      BEQ:  cond = (rs1 == rs2);
      BNE:  cond = (rs1 != rs2);
      BLT:  cond = ($signed(rs1) <  $signed(rs2));
      BGE:  cond = ($signed(rs1) >= $signed(rs2));
      BLTU: cond = (rs1 <  rs2);
      BGEU: cond = (rs1 >= rs2);
      default: begin
        cond      = 1'b0;
        funct3_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolver: computes the next PC for RV32I conditional
// branches and registers it together with taken/exception flags.
module branch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] iaddr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] pc,
  output logic            taken,
  output logic            out_valid,
  output logic            illegal,
  output logic            misaligned
);

  logic            w_is_branch;
  logic            w_cond;
  logic            w_funct3_ok;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fallthrough;
  logic [XLEN-1:0] w_pc_d;
  logic            w_taken_d;
  logic            w_illegal_d;
  logic            w_misaligned_d;
  logic            w_unused_instr_bits;

  logic [XLEN-1:0] r_pc;
  logic            r_taken;
  logic            r_out_valid;
  logic            r_illegal;
  logic            r_misaligned;

  // Only opcode and funct3 matter here; the remaining fields are ignored.
  assign w_unused_instr_bits = ^{instr[XLEN-1:15], instr[11:7]};

  assign w_is_branch = is_branch_opc(instr[6:0]);

  branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .funct3    (instr[14:12]),
    .rs1       (rs1),
    .rs2       (rs2),
    .cond      (w_cond),
    .funct3_ok (w_funct3_ok)
  );

  // Both adders wrap modulo 2^XLEN; the target drops bit 0 like JALR does.
  assign w_sum         = iaddr + imm;
  assign w_target      = w_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
  assign w_fallthrough = iaddr + {{(XLEN-3){1'b0}}, 3'd4};

  // Next-state selection: a taken branch to a non word-aligned target is
  // reported as misaligned and falls through instead of redirecting.
  always_comb begin
    w_pc_d         = w_fallthrough;
    w_taken_d      = 1'b0;
    w_illegal_d    = 1'b0;
    w_misaligned_d = 1'b0;
    if (w_is_branch) begin
      if (!w_funct3_ok) begin
        w_illegal_d = 1'b1;
      end else if (w_cond) begin
        if (w_target[1]) begin
          w_misaligned_d = 1'b1;
        end else begin
          w_pc_d    = w_target;
          w_taken_d = 1'b1;
        end
      end else begin
        w_pc_d = w_fallthrough;
      end
    end else begin
      w_pc_d = w_fallthrough;
    end
  end

  // Output registers: reset wins; otherwise load on in_valid, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_taken      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_illegal    <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_pc         <= w_pc_d;
        r_taken      <= w_taken_d;
        r_illegal    <= w_illegal_d;
        r_misaligned <= w_misaligned_d;
      end
    end
  end

  assign pc         = r_pc;
  assign taken      = r_taken;
  assign out_valid  = r_out_valid;
  assign illegal    = r_illegal;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed cases then random traffic
// compared against an arithmetic reference model.
module tb_branch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr, iaddr, imm, rs1, rs2;
  logic [31:0] pc;
  logic        taken, out_valid, illegal, misaligned;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0] exp_pc;
  logic        exp_taken, exp_ov, exp_ill, exp_mis;

  branch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .instr      (instr),
    .iaddr      (iaddr),
    .imm        (imm),
    .rs1        (rs1),
    .rs2        (rs2),
    .pc         (pc),
    .taken      (taken),
    .out_valid  (out_valid),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: the spec's rules in plain integer arithmetic.
  function automatic void model(input logic [31:0] ins, ia, im, a, b);
    bit              isb, ok, c, tc;
    int              f3;
    longint unsigned sum;
    logic [31:0]     tgt, fall;
    isb = (ins[6:0] == 7'h63);
    f3  = int'(ins[14:12]);
    ok  = 1'b1;
    c   = 1'b0;
    case (f3)
      0: c = (a == b);
      1: c = (a != b);
      4: c = (int'(a) <  int'(b));
      5: c = (int'(a) >= int'(b));
      6: c = (longint'({32'd0, a}) <  longint'({32'd0, b}));
      7: c = (longint'({32'd0, a}) >= longint'({32'd0, b}));
      default: ok = 1'b0;
    endcase
    sum  = ({32'd0, ia} + {32'd0, im}) % 64'h1_0000_0000;
    tgt  = sum[31:0];
    tgt  = tgt & 32'hFFFF_FFFE;
    sum  = ({32'd0, ia} + 64'd4) % 64'h1_0000_0000;
    fall = sum[31:0];
    tc        = isb && ok && c;
    exp_ill   = isb && !ok;
    exp_mis   = tc && tgt[1];
    exp_taken = tc && !tgt[1];
    exp_pc    = exp_taken ? tgt : fall;
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    logic [31:0] r;
    r = $urandom();
    return {r[31:15], f3, r[11:7], opc};
  endfunction

  task automatic step(input string tag, input logic v, input logic [31:0] ins, ia, im, a, b);
    @(negedge clk);
    in_valid = v; instr = ins; iaddr = ia; imm = im; rs1 = a; rs2 = b;
    if (v) model(ins, ia, im, a, b);
    exp_ov = v;
    @(posedge clk);
    #1;
    check({tag, ".pc"},    pc,                 exp_pc);
    check({tag, ".taken"}, {31'd0, taken},     {31'd0, exp_taken});
    check({tag, ".ov"},    {31'd0, out_valid}, {31'd0, exp_ov});
    check({tag, ".ill"},   {31'd0, illegal},   {31'd0, exp_ill});
    check({tag, ".mis"},   {31'd0, misaligned},{31'd0, exp_mis});
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, ia, im, ins;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic        v;

    rst = 1'b1; in_valid = 1'b1;
    instr = mk(3'b000, 7'h63); iaddr = 32'h100; imm = 32'h40; rs1 = 32'd1; rs2 = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc",    pc,                  RST_PC);
    check("rst.taken", {31'd0, taken},      32'd0);
    check("rst.ov",    {31'd0, out_valid},  32'd0);
    check("rst.ill",   {31'd0, illegal},    32'd0);
    check("rst.mis",   {31'd0, misaligned}, 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    exp_pc = RST_PC; exp_taken = 1'b0; exp_ill = 1'b0; exp_mis = 1'b0;
    step("hold0", 1'b0, mk(3'b000, 7'h63), 32'h100, 32'h40, 32'd10, 32'd10);
    check("hold0.const", pc, RST_PC);

    step("beq_t",  1'b1, mk(3'b000, 7'h63), 32'h100, 32'h40, 32'd10, 32'd10);
    check("beq_t.const", pc, 32'h140);
    step("beq_n",  1'b1, mk(3'b000, 7'h63), 32'h100, 32'h40, 32'd5,  32'd10);
    check("beq_n.const", pc, 32'h104);
    step("bne_n",  1'b1, mk(3'b001, 7'h63), 32'h100, 32'h40, 32'd10, 32'd10);
    step("bne_t",  1'b1, mk(3'b001, 7'h63), 32'h100, 32'h40, 32'd5,  32'd10);
    step("blt_n",  1'b1, mk(3'b100, 7'h63), 32'h200, 32'hFFFF_FFF8, 32'd10, 32'd5);
    check("blt_n.const", pc, 32'h204);
    step("bge_t",  1'b1, mk(3'b101, 7'h63), 32'h200, 32'hFFFF_FFF8, 32'd10, 32'd5);
    check("bge_t.const", pc, 32'h1F8);
    step("blt_t",  1'b1, mk(3'b100, 7'h63), 32'h200, 32'hFFFF_FFF8, 32'd10, 32'd15);
    step("bge_n",  1'b1, mk(3'b101, 7'h63), 32'h200, 32'hFFFF_FFF8, 32'd10, 32'd15);
    step("bge_eq", 1'b1, mk(3'b101, 7'h63), 32'h200, 32'hFFFF_FFF8, 32'd7,  32'd7);
    step("bltu_n", 1'b1, mk(3'b110, 7'h63), 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1);
    check("bltu_n.const", {31'd0, taken}, 32'd0);
    step("bgeu_t", 1'b1, mk(3'b111, 7'h63), 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1);
    check("bgeu_t.const", {31'd0, taken}, 32'd1);
    step("blt_sb", 1'b1, mk(3'b100, 7'h63), 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1);
    check("blt_sb.const", {31'd0, taken}, 32'd1);
    step("ill010", 1'b1, mk(3'b010, 7'h63), 32'h300, 32'h10, 32'd1, 32'd1);
    check("ill010.const", {31'd0, illegal}, 32'd1);
    step("ill011", 1'b1, mk(3'b011, 7'h63), 32'h300, 32'h10, 32'd1, 32'd2);
    step("misal",  1'b1, mk(3'b000, 7'h63), 32'h100, 32'h102, 32'd3, 32'd3);
    check("misal.const", {31'd0, misaligned}, 32'd1);
    check("misal.pc",    pc, 32'h104);
    step("hold1",  1'b0, mk(3'b001, 7'h63), 32'h500, 32'h40, 32'd1, 32'd2);
    check("hold1.const", pc, 32'h104);
    step("wrap",   1'b1, mk(3'b000, 7'h63), 32'hFFFF_FFFC, 32'h40, 32'd1, 32'd2);
    check("wrap.const", pc, 32'h0);
    step("twrap",  1'b1, mk(3'b000, 7'h63), 32'hFFFF_FFF0, 32'h20, 32'd1, 32'd1);
    step("nonbr",  1'b1, mk(3'b000, 7'h13), 32'h400, 32'h40, 32'd9, 32'd9);
    check("nonbr.const", pc, 32'h404);

    for (int i = 0; i < 300; i++) begin
      f3  = 3'($urandom_range(0, 7));
      opc = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : 7'h63;
      ins = mk(f3, opc);
      a   = pick_op();
      b   = ($urandom_range(0, 3) == 0) ? a : pick_op();
      ia  = {$urandom()} & 32'hFFFF_FFFC;
      im  = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 8191)) - 32'd4096) : $urandom();
      v   = ($urandom_range(0, 4) != 0);
      step("rand", v, ins, ia, im, a, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
